// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies a stable lock, retries on timeout,
// and holds the system in reset until lock is trusted. Define PLL_SEQ_LOSS_COUNT_EN to count lock losses.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_rst_n,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  localparam logic [15:0] RstLast     = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] StableLast  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  MaxRetries  = 2'(MAX_RETRIES);

  logic        lock_meta_q, lock_sync_q;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d;

  // One shared counter: each state restarts it on entry and leaves before its limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    retry_d = retry_q;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a timeout on the same edge.
        if (lock_sync_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
          if (retry_q < MaxRetries) begin
            retry_d = retry_q + 2'd1;
            state_d = StPllRst;
          end else begin
            state_d = StFail;
          end
        end
      end
      StStable: begin
        if (!lock_sync_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_sync_q) begin
          state_d = StPllRst;
          retry_d = '0;
        end
      end
      StFail: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_n   <= 1'b0;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_n   <= !((state_d == StPllRst) || (state_d == StFail));
      sys_rst     <= (state_d != StRun);
      ready       <= (state_d == StRun);
      fail        <= (state_d == StFail);
    end
  end

  assign retry_count = retry_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_q;
  logic       lost;

  assign lost = (state_q == StRun) && !lock_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loss_q <= '0;
    end else if (lost && (loss_q != 8'hff)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up scenarios plus random lock waveforms,
// all checked cycle by cycle against a phase/countdown reference model.
module tb_pll_lock_sequencer;

  localparam int PRST = 4;
  localparam int STAB = 8;
  localparam int TO   = 32;
  localparam int MAXR = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FAIL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst_n, sys_rst, ready, fail;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_vec = 0;
  int n_err = 0;

  int m_phase, m_left, m_good, m_retries, m_losses;
  bit pipe[$];

  pll_lock_sequencer #(
    .PLL_RST_CYCLES     (PRST),
    .LOCK_STABLE_CYCLES (STAB),
    .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .locked         (locked),
    .pll_rst_n      (pll_rst_n),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase   = PH_RST;
    m_left    = PRST;
    m_good    = 0;
    m_retries = 0;
    m_losses  = 0;
    pipe.delete();
    pipe.push_back(1'b0);
    pipe.push_back(1'b0);
  endfunction

  // The FSM reacts to the lock level sampled two edges earlier.
  function automatic void model_edge(input bit lk);
    bit ls;
    ls = pipe.pop_front();
    pipe.push_back(lk);
    case (m_phase)
      PH_RST: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = PH_WAIT;
          m_left  = TO;
        end
      end
      PH_WAIT: begin
        if (ls) begin
          m_phase = PH_STAB;
          m_good  = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_retries < MAXR) begin
              m_retries++;
              m_phase = PH_RST;
              m_left  = PRST;
            end else begin
              m_phase = PH_FAIL;
            end
          end
        end
      end
      PH_STAB: begin
        if (!ls) begin
          m_phase = PH_WAIT;
          m_left  = TO;
        end else begin
          m_good++;
          if (m_good == STAB) m_phase = PH_RUN;
        end
      end
      PH_RUN: begin
        if (!ls) begin
          m_losses  = (m_losses < 255) ? m_losses + 1 : 255;
          m_retries = 0;
          m_phase   = PH_RST;
          m_left    = PRST;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_loss();
`ifdef PLL_SEQ_LOSS_COUNT_EN
    return m_losses;
`else
    return 0;
`endif
  endfunction

  task automatic compare_model();
    check_eq("pll_rst_n", pll_rst_n, (m_phase == PH_RST || m_phase == PH_FAIL) ? 0 : 1);
    check_eq("sys_rst", sys_rst, (m_phase == PH_RUN) ? 0 : 1);
    check_eq("ready", ready, (m_phase == PH_RUN) ? 1 : 0);
    check_eq("fail", fail, (m_phase == PH_FAIL) ? 1 : 0);
    check_eq("retry_count", retry_count, m_retries);
    check_eq("lock_loss_count", lock_loss_count, exp_loss());
  endtask

  // Starts and ends on a falling edge.
  task automatic step(input bit lk);
    compare_model();
    locked = lk;
    @(posedge clk);
    model_edge(lk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pll_rst_n"}, pll_rst_n, 0);
    check_eq({tag, "_sys_rst"}, sys_rst, 1);
    check_eq({tag, "_ready"}, ready, 0);
    check_eq({tag, "_fail"}, fail, 0);
    check_eq({tag, "_retry"}, retry_count, 0);
    check_eq({tag, "_loss"}, lock_loss_count, 0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    locked = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("in_reset");
    reset = 1'b0;
    model_reset();
  endtask

  // First step samples locked=1; sys_rst must fall exactly on the tenth edge after it.
  task automatic lat_check(input string tag);
    step(1'b1);
    repeat (STAB + 1) step(1'b1);
    check_eq({tag, "_sys_rst_pre"}, sys_rst, 1);
    step(1'b1);
    check_eq({tag, "_sys_rst_rel"}, sys_rst, 0);
    check_eq({tag, "_ready"}, ready, 1);
  endtask

  initial begin
    int lows, rises;
    logic prev;

    @(negedge clk);

    // Nominal bring-up.
    do_reset();
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_rst_n == 1'b0) lows++;
      step(1'b0);
    end
    check_eq("prst_width", lows, PRST);
    lat_check("nominal");

    // Lock loss in RUN.
    repeat (3) step(1'b0);
    check_eq("loss_sys_rst", sys_rst, 1);
    check_eq("loss_pll_rst_n", pll_rst_n, 0);
    check_eq("loss_retry", retry_count, 0);
`ifdef PLL_SEQ_LOSS_COUNT_EN
    check_eq("loss_count", lock_loss_count, 1);
`else
    check_eq("loss_count", lock_loss_count, 0);
`endif
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      if (pll_rst_n == 1'b0) lows++;
      step(1'b1);
    end
    check_eq("reprst_width", lows, PRST);
    repeat (20) step(1'b1);

    // Lock never arrives.
    do_reset();
    rises = 0;
    prev  = pll_rst_n;
    for (int i = 0; i < 3 * (PRST + TO) + 20; i++) begin
      step(1'b0);
      if (pll_rst_n && !prev) rises++;
      prev = pll_rst_n;
    end
    check_eq("nolock_pulses", rises, 3);
    check_eq("nolock_fail", fail, 1);
    check_eq("nolock_retry", retry_count, MAXR);
    check_eq("nolock_pll_rst_n", pll_rst_n, 0);
    check_eq("nolock_sys_rst", sys_rst, 1);
    repeat (60) step(1'b0);

    // Unstable lock, then a good one.
    do_reset();
    repeat (10) step(1'b0);
    repeat (5) step(1'b1);
    repeat (2) step(1'b0);
    check_eq("unstable_sys_rst", sys_rst, 1);
    lat_check("unstable");

    // Lock seen by the FSM exactly on the timeout edge.
    do_reset();
    repeat (PRST + TO - 3) step(1'b0);
    repeat (3) step(1'b1);
    check_eq("bnd_pll_rst_n", pll_rst_n, 1);
    check_eq("bnd_retry", retry_count, 0);
    check_eq("bnd_sys_rst", sys_rst, 1);
    repeat (12) step(1'b1);

    // Asynchronous reset mid-STABLE, between edges.
    do_reset();
    repeat (10) step(1'b0);
    repeat (5) step(1'b1);
    check_eq("stable_pll_rst_n", pll_rst_n, 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("async");
    @(negedge clk);
    reset  = 1'b0;
    locked = 1'b0;
    model_reset();
    repeat (10) step(1'b0);
    lat_check("after_reset");

    // Random lock waveforms.
    for (int ep = 0; ep < 8; ep++) begin
      int n;
      do_reset();
      n = 0;
      while (n < 300) begin
        bit lvl;
        int len;
        lvl = 1'($urandom_range(0, 1));
        len = lvl ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 45));
        for (int j = 0; j < len; j++) step(lvl);
        n += len;
      end
    end
    compare_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
